// File: rtl/alien_spawn_scheduler_pkg.sv
// alien_spawn_scheduler_pkg
//   Shared types and constants for the alien spawn scheduler:
//   slot state (FREE/LAUNCH/FLYING), game state (IDLE/RUN/OVER),
//   angle width and the 16-bit Fibonacci LFSR taps (16,14,13,11).
package alien_spawn_scheduler_pkg;

    localparam int unsigned ANGLE_W   = 4;

    // Taps 16,14,13,11 mapped onto bits [15],[13],[12],[10] of a left-shifting register
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        SLOT_FREE   = 2'd0,
        SLOT_LAUNCH = 2'd1,
        SLOT_FLYING = 2'd2
    } slot_state_t;

    typedef enum logic [1:0] {
        G_IDLE = 2'd0,
        G_RUN  = 2'd1,
        G_OVER = 2'd2
    } game_state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/alien_spawn_scheduler_spawn_slot_fsm.sv
// spawn_slot_fsm
//   Per-slot lifecycle of one trajectory generator: FREE -> LAUNCH -> FLYING -> FREE.
//   Latches the entry angle on a grant and holds it for the whole flight,
//   reclaims the slot if the generator is not ready within LAUNCH_TIMEOUT cycles.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_clear         force the slot FREE (game leaving RUN)
//   i_grant         spawn grant for this slot (acted on only while FREE)
//   i_angle         angle to latch on grant
//   i_ready         generator ready
//   i_collision     generator collision flag
//   i_kill          alien shot by the player
//   o_spawn         generator parked/reset (high while FREE)
//   o_active        slot occupied
//   o_free          slot grantable this cycle
//   o_life_lost     FLYING alien collided this cycle
//   o_killed        FLYING alien shot this cycle (collision has priority)
//   o_angle         held angle
module spawn_slot_fsm
    import alien_spawn_scheduler_pkg::*;
#(
    parameter int unsigned LAUNCH_TIMEOUT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_grant,
    input  logic [ANGLE_W-1:0] i_angle,
    input  logic               i_ready,
    input  logic               i_collision,
    input  logic               i_kill,
    output logic               o_spawn,
    output logic               o_active,
    output logic               o_free,
    output logic               o_life_lost,
    output logic               o_killed,
    output logic [ANGLE_W-1:0] o_angle
);

    localparam int unsigned TW = (LAUNCH_TIMEOUT > 1) ? $clog2(LAUNCH_TIMEOUT) : 1;

    slot_state_t        r_state;
    slot_state_t        w_state_next;
    logic [TW-1:0]      r_timer;
    logic [ANGLE_W-1:0] r_angle;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SLOT_FREE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (i_clear) begin
            w_state_next = SLOT_FREE;
        end else begin
            case (r_state)
                SLOT_FREE: begin
                    if (i_grant) w_state_next = SLOT_LAUNCH;
                end
                SLOT_LAUNCH: begin
                    if (i_ready) begin
                        w_state_next = SLOT_FLYING;
                    end else if (r_timer == '0) begin
                        w_state_next = SLOT_FREE;
                    end
                end
                SLOT_FLYING: begin
                    if (i_collision || i_kill || !i_ready) w_state_next = SLOT_FREE;
                end
                default: w_state_next = SLOT_FREE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        o_free      = (r_state == SLOT_FREE);
        o_spawn     = (r_state == SLOT_FREE);
        o_active    = (r_state != SLOT_FREE);
        o_life_lost = (r_state == SLOT_FLYING) && i_collision;
        o_killed    = (r_state == SLOT_FLYING) && !i_collision && i_kill;
    end

    // Timer is preloaded while FREE so the first LAUNCH cycle sees the full budget
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (r_state == SLOT_FREE) begin
            r_timer <= TW'(LAUNCH_TIMEOUT - 1);
        end else if (r_state == SLOT_LAUNCH && r_timer != '0) begin
            r_timer <= r_timer - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_angle <= '0;
        end else if (i_grant && !i_clear && r_state == SLOT_FREE) begin
            r_angle <= i_angle;
        end
    end

    assign o_angle = r_angle;

endmodule

// File: rtl/alien_spawn_scheduler.sv
// alien_spawn_scheduler
//   Game FSM, spawn interval timer, round-robin grant, LFSR angle source and
//   lives/score bookkeeping for a bank of N_SLOTS trajectory generators.
//   Optional macro DIFFICULTY_RAMP_EN: every 8 grants the spawn period shrinks
//   by period>>3 (floor 8 cycles); entering RUN restores SPAWN_INTERVAL.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           begin a game from IDLE or GAME_OVER
//   gen_ready       per-slot generator ready
//   gen_collision   per-slot generator collision
//   kill            per-slot alien shot
//   spawn           per-slot spawn/park
//   angle_bus       per-slot angle, slot i at [4i+3:4i]
//   active          per-slot occupied
//   lives, score    game counters
//   playing         game in RUN
//   game_over       game in OVER
module alien_spawn_scheduler
    import alien_spawn_scheduler_pkg::*;
#(
    parameter int unsigned N_SLOTS        = 4,
    parameter logic [15:0] SPAWN_INTERVAL = 16'd60,
    parameter int unsigned LAUNCH_TIMEOUT = 4,
    parameter logic [2:0]  INIT_LIVES     = 3'd3,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [N_SLOTS-1:0]           gen_ready,
    input  logic [N_SLOTS-1:0]           gen_collision,
    input  logic [N_SLOTS-1:0]           kill,
    output logic [N_SLOTS-1:0]           spawn,
    output logic [ANGLE_W*N_SLOTS-1:0]   angle_bus,
    output logic [N_SLOTS-1:0]           active,
    output logic [2:0]                   lives,
    output logic [15:0]                  score,
    output logic                         playing,
    output logic                         game_over
);

    localparam int unsigned RRW = $clog2(N_SLOTS);

    game_state_t        r_game;
    game_state_t        w_game_next;
    logic [15:0]        r_lfsr;
    logic [15:0]        r_interval;
    logic [15:0]        w_reload;
    logic [RRW-1:0]     r_rr;
    logic [2:0]         r_lives;
    logic [15:0]        r_score;

    logic [N_SLOTS-1:0] w_slot_free;
    logic [N_SLOTS-1:0] w_life_lost;
    logic [N_SLOTS-1:0] w_killed;
    logic [N_SLOTS-1:0] w_grant_vec;
    logic               w_clear;
    logic               w_enter_run;
    logic               w_run_stay;
    logic               w_grant;
    logic               w_hit_hi;
    logic               w_hit_lo;
    logic [RRW-1:0]     w_idx_hi;
    logic [RRW-1:0]     w_idx_lo;
    logic [RRW-1:0]     w_grant_idx;
    logic [3:0]         w_lost_cnt;
    logic [3:0]         w_kill_cnt;
    logic [2:0]         w_lives_next;
    logic [16:0]        w_score_sum;
    logic [15:0]        w_score_next;

    // ---------------- game FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_game <= G_IDLE;
        end else begin
            r_game <= w_game_next;
        end
    end

    always_comb begin
        w_game_next = r_game;
        case (r_game)
            G_IDLE, G_OVER: if (start) w_game_next = G_RUN;
            G_RUN:          if (w_lives_next == '0) w_game_next = G_OVER;
            default:        w_game_next = G_IDLE;
        endcase
    end

    always_comb begin
        playing   = (r_game == G_RUN);
        game_over = (r_game == G_OVER);
    end

    assign w_enter_run = (r_game != G_RUN) && start;
    assign w_run_stay  = (r_game == G_RUN) && (w_game_next == G_RUN);
    assign w_clear     = (w_game_next != G_RUN);

    // ---------------- LFSR ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    // ---------------- round-robin grant ----------------
    // Two passes: first FREE slot at/after rr_ptr, else first FREE slot overall (wrap).
    always_comb begin
        w_hit_hi = 1'b0;
        w_hit_lo = 1'b0;
        w_idx_hi = '0;
        w_idx_lo = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            if (w_slot_free[i] && !w_hit_lo) begin
                w_hit_lo = 1'b1;
                w_idx_lo = RRW'(i);
            end
            if (w_slot_free[i] && (RRW'(i) >= r_rr) && !w_hit_hi) begin
                w_hit_hi = 1'b1;
                w_idx_hi = RRW'(i);
            end
        end
    end

    // A zero interval counter is the pending state; it holds at zero until a slot frees.
    assign w_grant_idx = w_hit_hi ? w_idx_hi : w_idx_lo;
    assign w_grant     = w_run_stay && (r_interval == '0) && w_hit_lo;

    always_comb begin
        w_grant_vec = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            w_grant_vec[i] = w_grant && (w_grant_idx == RRW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr <= '0;
        end else if (w_grant) begin
            r_rr <= (w_grant_idx == RRW'(N_SLOTS - 1)) ? '0 : w_grant_idx + 1'b1;
        end
    end

    // ---------------- spawn interval ----------------
`ifdef DIFFICULTY_RAMP_EN
    logic [15:0] r_period;
    logic [2:0]  r_grant_cnt;
    logic [15:0] w_period_dec;

    always_comb begin
        w_period_dec = r_period - (r_period >> 3);
        if (w_period_dec < 16'd8) w_period_dec = (r_period < 16'd8) ? r_period : 16'd8;
    end

    // The eighth grant already reloads with the shortened period
    assign w_reload = ((r_grant_cnt == 3'd7) ? w_period_dec : r_period) - 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period    <= SPAWN_INTERVAL;
            r_grant_cnt <= '0;
        end else if (w_enter_run) begin
            r_period    <= SPAWN_INTERVAL;
            r_grant_cnt <= '0;
        end else if (w_grant) begin
            r_grant_cnt <= r_grant_cnt + 1'b1;
            if (r_grant_cnt == 3'd7) r_period <= w_period_dec;
        end
    end
`else
    assign w_reload = SPAWN_INTERVAL - 16'd1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_interval <= '0;
        end else if (w_enter_run) begin
            r_interval <= SPAWN_INTERVAL - 16'd1;
        end else if (w_run_stay) begin
            if (r_interval != '0) begin
                r_interval <= r_interval - 16'd1;
            end else if (w_grant) begin
                r_interval <= w_reload;
            end
        end
    end

    // ---------------- lives / score ----------------
    always_comb begin
        w_lost_cnt = '0;
        w_kill_cnt = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            w_lost_cnt = w_lost_cnt + {3'b000, w_life_lost[i]};
            w_kill_cnt = w_kill_cnt + {3'b000, w_killed[i]};
        end
        if ({1'b0, r_lives} <= w_lost_cnt) begin
            w_lives_next = '0;
        end else begin
            w_lives_next = r_lives - w_lost_cnt[2:0];
        end
        w_score_sum  = {1'b0, r_score} + {13'b0, w_kill_cnt};
        w_score_next = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
    end

    // Kills in the cycle that ends the game are not counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lives <= '0;
            r_score <= '0;
        end else if (w_enter_run) begin
            r_lives <= INIT_LIVES;
            r_score <= '0;
        end else if (r_game == G_RUN) begin
            r_lives <= w_lives_next;
            if (w_run_stay) r_score <= w_score_next;
        end
    end

    assign lives = r_lives;
    assign score = r_score;

    // ---------------- slot array ----------------
    for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
        spawn_slot_fsm #(
            .LAUNCH_TIMEOUT(LAUNCH_TIMEOUT)
        ) u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_clear     (w_clear),
            .i_grant     (w_grant_vec[g]),
            .i_angle     (r_lfsr[ANGLE_W-1:0]),
            .i_ready     (gen_ready[g]),
            .i_collision (gen_collision[g]),
            .i_kill      (kill[g]),
            .o_spawn     (spawn[g]),
            .o_active    (active[g]),
            .o_free      (w_slot_free[g]),
            .o_life_lost (w_life_lost[g]),
            .o_killed    (w_killed[g]),
            .o_angle     (angle_bus[ANGLE_W*g +: ANGLE_W])
        );
    end

endmodule
